// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TXD/RXD/CON registers and a level IRQ.
// rdata is combinational so the CPU sees it with data-memory read timing.
module uart_mmio #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] ADDR_TXD = 8'h18,
    parameter logic [7:0] ADDR_RXD = 8'h1C,
    parameter logic [7:0] ADDR_CON = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        UART_RX,
    output logic        UART_TX,
    output logic        irqout
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, tx_byte_q, tx_byte_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic          tx_line_q, tx_line_d, tx_done_q, tx_done_d, tx_set_done;
    logic          rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_done;
    logic          tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d, irq_q;
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic          sel_txd, sel_rxd, sel_con, wr_txd, rd_rxd, rd_con, tx_busy;
    logic          unused_ok;

    assign unused_ok = &{1'b0, addr[31:8], wdata[31:8]};
    assign sel_txd   = addr[7:0] == ADDR_TXD;
    assign sel_rxd   = addr[7:0] == ADDR_RXD;
    assign sel_con   = addr[7:0] == ADDR_CON;
    assign wr_txd    = wr & sel_txd;
    assign rd_rxd    = rd & sel_rxd;
    assign rd_con    = rd & sel_con;
    assign tx_busy   = tx_state_q != IDLE;
    assign UART_TX   = tx_line_q;
    assign irqout    = irq_q;

    assign rdata = !rd    ? 32'd0 :
                   sel_txd ? {24'd0, tx_byte_q} :
                   sel_rxd ? {24'd0, rx_data_q} :
                   sel_con ? {26'd0, rx_overrun_q, tx_busy, rx_valid_q, tx_done_q, rx_irq_en_q, tx_irq_en_q} :
                             32'd0;

    // Counters load a period and the state acts on the cycle the count reaches one.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q - ONE;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_byte_d   = tx_byte_q;
        tx_line_d   = tx_line_q;
        tx_set_done = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = FULL;
                if (wr_txd) begin
                    tx_state_d = START;
                    tx_byte_d  = wdata[7:0];
                    tx_shift_d = wdata[7:0];
                    tx_line_d  = 1'b0;
                end
            end
            START: if (tx_cnt_q == ONE) begin
                tx_state_d = DATA;
                tx_cnt_d   = FULL;
                tx_bit_d   = 3'd0;
                tx_line_d  = tx_shift_q[0];
            end
            DATA: if (tx_cnt_q == ONE) begin
                tx_cnt_d   = FULL;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_line_d  = tx_bit_q == 3'd7 ? 1'b1 : tx_shift_q[1];
                tx_state_d = tx_bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (tx_cnt_q == ONE) begin
                tx_state_d  = IDLE;
                tx_set_done = 1'b1;
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - ONE;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = HALF;
                rx_state_d = (rx_s3_q & ~rx_s2_q) ? START : IDLE;
            end
            START: if (rx_cnt_q == ONE) begin
                rx_cnt_d   = FULL;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == ONE) begin
                rx_cnt_d   = FULL;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_state_d = rx_bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (rx_cnt_q == ONE) begin
                rx_state_d = IDLE;
                rx_done    = rx_s2_q;
            end
        endcase
    end

    // A flag being set in the same cycle as a clearing read keeps the set.
    assign tx_done_d    = tx_set_done | (tx_done_q & ~rd_con);
    assign rx_data_d    = rx_done ? rx_shift_q : rx_data_q;
    assign rx_valid_d   = rx_done | (rx_valid_q & ~rd_rxd);
    assign rx_overrun_d = rx_done ? (rx_overrun_q | (rx_valid_q & ~rd_rxd)) : (rx_overrun_q & ~rd_rxd);
    assign tx_irq_en_d  = (wr & sel_con) ? wdata[0] : tx_irq_en_q;
    assign rx_irq_en_d  = (wr & sel_con) ? wdata[1] : rx_irq_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= IDLE;
            rx_state_q   <= IDLE;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            rx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_byte_q    <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            tx_line_q    <= 1'b1;
            tx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            tx_irq_en_q  <= 1'b0;
            rx_irq_en_q  <= 1'b0;
            irq_q        <= 1'b0;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            rx_bit_q     <= rx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_byte_q    <= tx_byte_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            tx_line_q    <= tx_line_d;
            tx_done_q    <= tx_done_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            tx_irq_en_q  <= tx_irq_en_d;
            rx_irq_en_q  <= rx_irq_en_d;
            irq_q        <= (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
            rx_s1_q      <= UART_RX;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
        end
    end
endmodule
